// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix operand buffer.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_fill_addr.sv
// Row/column address generator for streamed fills, row-major or column-major order.
module matrix_fill_addr
    import mm_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      restart,
    input  logic                      step,
    input  logic                      colmaj,
    output logic [idx_w(ROWS)-1:0]    row,
    output logic [idx_w(COLS)-1:0]    col,
    output logic                      last_c
);

    localparam int unsigned RW = idx_w(ROWS);
    localparam int unsigned CLW = idx_w(COLS);

    logic row_end;
    logic col_end;

    assign row_end = (row == RW'(ROWS - 1));
    assign col_end = (col == CLW'(COLS - 1));
    // Both orders finish on the bottom-right element.
    assign last_c  = row_end && col_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (restart) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (last_c) begin
                row <= '0;
                col <= '0;
            end else if (colmaj) begin
                if (row_end) begin
                    row <= '0;
                    col <= col + CLW'(1);
                end else begin
                    row <= row + RW'(1);
                end
            end else begin
                if (col_end) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CLW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_load_buffer.sv
// Matrix operand store: parallel or streamed fill, flat output, registered read port.
module matrix_load_buffer
    import mm_pkg::*;
#(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               par_load,
    input  logic [ROWS*COLS*ELEM_W-1:0]        par_in,
    input  logic                               s_start,
    input  logic                               s_colmaj,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [ELEM_W-1:0]                  s_data,
    output logic                               full,
    output logic [$clog2(ROWS*COLS+1)-1:0]     fill_cnt,
    output logic [ROWS*COLS*ELEM_W-1:0]        out_flat,
    input  logic                               rd_en,
    input  logic [idx_w(ROWS)-1:0]             rd_row,
    input  logic [idx_w(COLS)-1:0]             rd_col,
    output logic [ELEM_W-1:0]                  rd_data,
    output logic                               rd_valid
);

    localparam int unsigned N   = ROWS * COLS;
    localparam int unsigned KW  = idx_w(N);
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned RW  = idx_w(ROWS);
    localparam int unsigned CLW = idx_w(COLS);

    state_t state_q, state_d;
    logic   colmaj_q;
    logic   wr_en;
    logic   restart;
    logic   beat;
    logic   last_c;
    logic [RW-1:0]     wr_row;
    logic [CLW-1:0]    wr_col;
    logic [KW-1:0]     wr_k;
    logic [KW-1:0]     rd_k;
    logic              rd_in_range;
    logic [ELEM_W-1:0] rd_mux;
    logic [ELEM_W-1:0] mem [N];

    matrix_fill_addr #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_addr (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .step    (wr_en),
        .colmaj  (colmaj_q),
        .row     (wr_row),
        .col     (wr_col),
        .last_c  (last_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; parallel load overrides everything
    always_comb begin
        state_d = state_q;
        if (par_load) begin
            state_d = ST_FULL;
        end else begin
            unique case (state_q)
                ST_IDLE: if (s_start) state_d = ST_FILL;
                ST_FILL: if (s_start)             state_d = ST_FILL;
                         else if (beat && last_c) state_d = ST_FULL;
                ST_FULL: if (s_start) state_d = ST_FILL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; a beat coinciding with s_start is dropped
    always_comb begin
        s_ready = 1'b0;
        beat    = 1'b0;
        wr_en   = 1'b0;
        restart = 1'b0;
        s_ready = (state_q == ST_FILL) && !par_load;
        beat    = s_valid && s_ready;
        restart = s_start && !par_load;
        wr_en   = beat && !s_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            fill_cnt <= '0;
            colmaj_q <= 1'b0;
        end else begin
            full <= (state_d == ST_FULL);
            if (par_load)     fill_cnt <= CW'(N);
            else if (restart) fill_cnt <= '0;
            else if (wr_en)   fill_cnt <= fill_cnt + CW'(1);
            if (restart) colmaj_q <= s_colmaj;
        end
    end

    assign wr_k = KW'(wr_row) * KW'(COLS) + KW'(wr_col);

    // Element storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) mem[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (par_load)                     mem[k] <= par_in[k*ELEM_W +: ELEM_W];
                else if (wr_en && wr_k == KW'(k)) mem[k] <= s_data;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_flat[g*ELEM_W +: ELEM_W] = mem[g];
    end

    // Read mux over pre-edge storage; out-of-range indices read as zero
    assign rd_in_range = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
    assign rd_k        = KW'(rd_row) * KW'(COLS) + KW'(rd_col);

    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (rd_in_range && rd_k == KW'(k)) rd_mux = mem[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: doc/matrix_load_buffer.md
Name: matrix_load_buffer

Overview:
Parametrised operand store for the matrix multiplier. Holds one ROWS x COLS matrix of ELEM_W-bit elements and presents it as a flat vector to the multiplier array. It can be loaded in one cycle from a flat bus, or streamed one element per cycle with a valid/ready handshake in row-major or column-major order. A registered random-access read port supports debug and readback.

Parameters:
ELEM_W, 16, element width in bits
ROWS, 4, matrix rows (>=1)
COLS, 4, matrix columns (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
par_load  in  1  load whole matrix from par_in this cycle
par_in  in  ROWS*COLS*ELEM_W  flat matrix input
s_start  in  1  begin a streamed fill; restarts at element 0
s_colmaj  in  1  order for this fill, sampled with s_start: 0=row-major, 1=column-major
s_valid  in  1  stream element valid
s_ready  out  1  buffer accepts a stream element
s_data  in  ELEM_W  stream element
full  out  1  matrix complete and stable
fill_cnt  out  $clog2(ROWS*COLS+1)  elements accepted in the current fill
out_flat  out  ROWS*COLS*ELEM_W  stored matrix
rd_en  in  1  read request
rd_row  in  $clog2(ROWS) (min 1)  read row index
rd_col  in  $clog2(COLS) (min 1)  read column index
rd_data  out  ELEM_W  read result
rd_valid  out  1  rd_data valid

Behaviour:
- Layout: element (r,c) has k=r*COLS+c and occupies out_flat[k*ELEM_W +: ELEM_W]. Bit 0 is the LSB of element (0,0). out_flat reflects the storage registers directly.
- Reset (async, rst_n=0): storage all zero; state IDLE; full=0; fill_cnt=0; rd_data=0; rd_valid=0; stored order bit=0.
- FSM states IDLE, FILL, FULL.
- IDLE: s_ready=0. s_start -> FILL with fill_cnt=0 and the order bit latched from s_colmaj.
- FILL: s_ready=1 unless par_load=1 in the same cycle (combinational).
  - Each beat with s_valid&s_ready writes s_data to the element at beat index i and increments fill_cnt.
  - Row-major: i maps to (i/COLS, i%COLS). Column-major: i maps to (i%ROWS, i/ROWS).
  - Use row and column counters, not division.
  - Beat ROWS*COLS-1 -> FULL; full=1 from the next cycle.
  - s_start in FILL restarts at i=0 and relatches the order bit. Any beat in that same cycle is discarded.
- FULL: s_ready=0; storage holds. s_start -> FILL; full=0 next cycle. Elements not yet rewritten keep their old values.
- par_load in any state: all storage <= par_in; state -> FULL; fill_cnt <= ROWS*COLS.
  - par_load has priority over s_start and over any stream beat in the same cycle.
- rd_en=1: next cycle rd_valid=1 and rd_data = element(rd_row, rd_col), read from pre-edge storage (write-then-read returns the old value in the same cycle).
  - Out-of-range index returns 0 with rd_valid=1.
  - rd_en=0 gives rd_valid=0 next cycle; rd_data holds.
- Reset asserted mid-fill aborts immediately to reset values. No partial state survives.

Decomposition:
- Shared package mm_pkg: state encoding typedef (IDLE/FILL/FULL) and helper function idx_w(n) returning max($clog2(n),1).
- One natural sub-module, matrix_fill_addr: row/col counters with row-major/col-major stepping, a last-beat flag and a sync restart. The top keeps the FSM, storage, parallel load and read port.

Test Plan:
- Reset: drive rst_n low mid-cycle -> out_flat=0, full=0, s_ready=0, fill_cnt=0 without waiting for a clock edge.
- Row-major stream (2x3, ELEM_W=8): s_start, then 6 beats 0x11..0x16 with s_valid gaps -> out_flat elements k0..k5 = 0x11..0x16; full=1 one cycle after the 6th beat; s_ready=0 after.
- Column-major stream (2x3): s_colmaj=1, beats 0xA0..0xA5 -> (0,0)=A0, (1,0)=A1, (0,1)=A2, (1,1)=A3, (0,2)=A4, (1,2)=A5.
- Parallel load collision (default 4x4): during FILL at fill_cnt=5, par_load with par_in=pattern P plus s_valid beat 0xFFFF -> out_flat=P, full=1, fill_cnt=16, beat not written.
- Restart: in FULL, s_start then 2 beats -> full=0; elements 0,1 new; elements 2..15 retain old values; fill_cnt=2.
- Read port: rd_en with (2,3) after a known load -> rd_data = element k=11 next cycle, rd_valid=1. With ROWS=3 and rd_row=3 -> rd_data=0, rd_valid=1.
